// File: rtl/des_key_schedule.sv
// Iterative DES round-key generator: one 48-bit subkey per valid/ready
// handshake, K1..K16 for encryption or K16..K1 for decryption.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   key_load      strobe: capture key_in/decrypt and (re)start the schedule
//   key_in[63:0]  DES key, DES bit 1 = key_in[63], parity bits ignored
//   decrypt       mode sampled with key_load (1 = K16..K1)
//   subkey_ready  consumer accepts the presented subkey
//   subkey_out    current round key (0 when not valid), DES bit 1 = [47]
//   subkey_valid  subkey_out is a valid round key
//   round_num     emission index 0..15 (0 when idle)
//   done          one-cycle pulse after the last subkey is accepted
module des_key_schedule #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic [47:0] subkey_out,
  output logic        subkey_valid,
  output logic [3:0]  round_num,
  output logic        done
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  state_t      state, state_n;
  logic [27:0] c, d, c_n, d_n;
  logic [3:0]  cnt, cnt_n;
  logic        dec, dec_n;
  logic        done_r, done_n;
  logic [55:0] pc1_out;
  logic [55:0] cd;
  logic [47:0] pc2_out;
  logic        one_bit;
  logic        unused_parity;

  assign unused_parity = ^{key_in[56], key_in[48], key_in[40],
                           key_in[32], key_in[24], key_in[16],
                           key_in[8],  key_in[0]};

  function automatic logic [27:0] rotl(input logic [27:0] x,
                                       input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x,
                                       input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  always_comb begin
    pc1_out = '0;
    for (int i = 0; i < 56; i++)
      pc1_out[55-i] = key_in[64-PC1[i]];
  end

  assign cd = {c, d};

  always_comb begin
    pc2_out = '0;
    for (int i = 0; i < 48; i++)
      pc2_out[47-i] = cd[56-PC2[i]];
  end

  // Encrypt uses S[cnt+2], decrypt S[16-cnt]; both pick the
  // single-bit shift at exactly cnt = 0, 7, 14.
  assign one_bit = (cnt == 4'd0) | (cnt == 4'd7) | (cnt == 4'd14);

  always_comb begin
    state_n = state;
    c_n     = c;
    d_n     = d;
    cnt_n   = cnt;
    dec_n   = dec;
    done_n  = 1'b0;
    if (key_load) begin
      // Unrotated PC-1 equals C16,D16 (total shift is 28).
      c_n     = decrypt ? pc1_out[55:28] : rotl(pc1_out[55:28], 1'b1);
      d_n     = decrypt ? pc1_out[27:0]  : rotl(pc1_out[27:0], 1'b1);
      cnt_n   = 4'd0;
      dec_n   = decrypt;
      state_n = ACTIVE;
    end else if (state == ACTIVE && subkey_ready) begin
      if (cnt == 4'(NUM_ROUNDS - 1)) begin
        state_n = IDLE;
        cnt_n   = 4'd0;
        done_n  = 1'b1;
      end else begin
        cnt_n = cnt + 4'd1;
        c_n   = dec ? rotr(c, one_bit) : rotl(c, one_bit);
        d_n   = dec ? rotr(d, one_bit) : rotl(d, one_bit);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      c      <= '0;
      d      <= '0;
      cnt    <= '0;
      dec    <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      c      <= c_n;
      d      <= d_n;
      cnt    <= cnt_n;
      dec    <= dec_n;
      done_r <= done_n;
    end
  end

  assign subkey_valid = (state == ACTIVE);
  assign subkey_out   = subkey_valid ? pc2_out : '0;
  assign round_num    = subkey_valid ? cnt : '0;
  assign done         = done_r;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule with an abstract subkey model
// (cumulative-rotation per round) checked every cycle.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_load;
  logic [63:0] key_in;
  logic        decrypt;
  logic        subkey_ready;
  logic [47:0] subkey_out;
  logic        subkey_valid;
  logic [3:0]  round_num;
  logic        done;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_load     (key_load),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .subkey_ready (subkey_ready),
    .subkey_out   (subkey_out),
    .subkey_valid (subkey_valid),
    .round_num    (round_num),
    .done         (done)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KA = 64'h133457799BBCDFF1;
  localparam logic [63:0] KB = 64'h0E329232EA6D0D73;
  localparam logic [63:0] W0 = 64'h0101010101010101;
  localparam logic [63:0] W1 = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [47:0] KA1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KA16 = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2,
                             1, 2, 2, 2, 2, 2, 2, 1};

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Round key r (1..16): rotate C0/D0 by the cumulative shift count.
  function automatic logic [47:0] rk(input logic [63:0] k, input int r);
    logic [27:0] c0, d0, c, d;
    logic [55:0] t;
    logic [47:0] s;
    int cum;
    int m;
    cum = 0;
    for (int j = 0; j < 28; j++) begin
      c0[27-j] = k[64-PC1[j]];
      d0[27-j] = k[64-PC1[28+j]];
    end
    for (int i = 0; i < r; i++) cum += SH[i];
    cum = cum % 28;
    t = {c0, c0} >> (28 - cum);
    c = t[27:0];
    t = {d0, d0} >> (28 - cum);
    d = t[27:0];
    for (int j = 0; j < 48; j++) begin
      m = PC2[j];
      s[47-j] = (m <= 28) ? c[28-m] : d[56-m];
    end
    return s;
  endfunction

  bit          m_act = 1'b0;
  bit          m_dec = 1'b0;
  bit          m_done = 1'b0;
  bit          hold = 1'b0;
  bit          chk_en = 1'b0;
  int          m_pos = 0;
  logic [63:0] m_key = '0;
  logic [47:0] held = '0;

  always @(posedge clk) begin
    hold = m_act && !subkey_ready && !key_load && !rst;
    held = subkey_out;
    if (rst) begin
      m_act  = 1'b0;
      m_pos  = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (key_load) begin
        m_key = key_in;
        m_dec = decrypt;
        m_act = 1'b1;
        m_pos = 0;
      end else if (m_act && subkey_ready) begin
        if (m_pos == 15) begin
          m_act  = 1'b0;
          m_pos  = 0;
          m_done = 1'b1;
        end else begin
          m_pos++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [47:0] e;
    if (chk_en) begin
      e = '0;
      if (m_act) e = m_dec ? rk(m_key, 16 - m_pos) : rk(m_key, m_pos + 1);
      check("valid", 64'(subkey_valid), 64'(m_act));
      check("subkey", 64'(subkey_out), 64'(e));
      check("round_num", 64'(round_num), 64'(m_pos));
      check("done", 64'(done), 64'(m_done));
      if (hold) check("stable", 64'(subkey_out), 64'(held));
    end
  end

  task automatic load(input logic [63:0] k, input bit dec);
    key_in   = k;
    decrypt  = dec;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  logic [47:0] first_k, last_k;
  int          ndone;
  bit          got;

  initial begin
    rst = 1'b1;
    key_load = 1'b0;
    key_in = '0;
    decrypt = 1'b0;
    subkey_ready = 1'b0;

    check("model_k1", 64'(rk(KA, 1)), 64'(KA1));
    check("model_k16", 64'(rk(KA, 16)), 64'(KA16));
    check("model_weak0", 64'(rk(W0, 7)), 64'h0);
    check("model_weak1", 64'(rk(W1, 9)), 64'hFFFFFFFFFFFF);

    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("idle_valid", 64'(subkey_valid), 64'h0);
      check("idle_out", 64'(subkey_out), 64'h0);
      check("idle_round", 64'(round_num), 64'h0);
      check("idle_done", 64'(done), 64'h0);
    end

    subkey_ready = 1'b1;
    load(KA, 1'b0);
    check("enc_k1", 64'(subkey_out), 64'(KA1));
    check("enc_r0", 64'(round_num), 64'h0);
    for (int i = 2; i <= 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        check("enc_k16", 64'(subkey_out), 64'(KA16));
        check("enc_r15", 64'(round_num), 64'd15);
      end
      if (i < 17) check("enc_nodone", 64'(done), 64'h0);
      else check("enc_done17", 64'(done), 64'h1);
    end

    load(W0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("weak0_v", 64'(subkey_valid), 64'h1);
      check("weak0_k", 64'(subkey_out), 64'h0);
      @(negedge clk);
    end
    check("weak0_done", 64'(done), 64'h1);
    load(W1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("weak1_k", 64'(subkey_out), 64'hFFFFFFFFFFFF);
      @(negedge clk);
    end
    check("weak1_done", 64'(done), 64'h1);

    subkey_ready = 1'($urandom_range(0, 1));
    load(KA, 1'b1);
    first_k = '0;
    last_k = '0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (subkey_valid && round_num == 4'd0) first_k = subkey_out;
      if (subkey_valid && round_num == 4'd15) last_k = subkey_out;
      if (done) got = 1'b1;
      else begin
        subkey_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    check("dec_done_seen", 64'(got), 64'h1);
    check("dec_first", 64'(first_k), 64'(KA16));
    check("dec_last", 64'(last_k), 64'(KA1));

    subkey_ready = 1'b1;
    ndone = 0;
    load(KA, 1'b0);
    repeat (5) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_r5", 64'(round_num), 64'd5);
    load(KB, 1'b0);
    check("abort_r0", 64'(round_num), 64'h0);
    check("abort_kb1", 64'(subkey_out), 64'(rk(KB, 1)));
    check("abort_v", 64'(subkey_valid), 64'h1);
    for (int i = 0; i < 16; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_done_end", 64'(done), 64'h1);
    if (done) ndone++;
    check("abort_ndone", 64'(ndone), 64'h1);

    load(KA, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (round_num == 4'd7) got = 1'b1;
      else @(negedge clk);
    end
    check("mid_r7", 64'(round_num), 64'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_valid", 64'(subkey_valid), 64'h0);
    check("mid_round", 64'(round_num), 64'h0);
    check("mid_done", 64'(done), 64'h0);
    load(KA, 1'b0);
    check("mid_k1", 64'(subkey_out), 64'(KA1));
    repeat (17) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
